// File: rtl/uart_frame_packer.sv
// Packs 16-bit samples into byte frames (SYNC0, SYNC1, LEN, payload MSB-first[, CSUM]) for a TX FIFO.
// Define PACKER_CHECKSUM_EN to append a modulo-256 checksum of LEN and the payload bytes.
module uart_frame_packer #(
  parameter int         N_WORDS = 4,
  parameter logic [7:0] SYNC0   = 8'hAA,
  parameter logic [7:0] SYNC1   = 8'h55
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  input  logic        full,
  input  logic        almost_full,
  output logic        wr_en,
  output logic [7:0]  din,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  localparam logic [7:0] LEN_BYTE  = 8'(2 * N_WORDS);
  localparam logic [6:0] LAST_WORD = 7'(N_WORDS);

  typedef enum logic [2:0] {
    IDLE, SYNC_A, SYNC_B, LEN, WORD, MSB, LSB
`ifdef PACKER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t      state_q;
  logic [15:0] word_q;
  logic [6:0]  word_cnt_q;
  logic        wr_en_q, frame_done_q;
  logic [7:0]  din_q;
  logic [15:0] frame_cnt_q;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic       emit, fire, last_byte;
  logic [7:0] byte_d;

  always_comb begin
    emit   = 1'b1;
    byte_d = 8'h00;
    case (state_q)
      SYNC_A:  byte_d = SYNC0;
      SYNC_B:  byte_d = SYNC1;
      LEN:     byte_d = LEN_BYTE;
      MSB:     byte_d = word_q[15:8];
      LSB:     byte_d = word_q[7:0];
`ifdef PACKER_CHECKSUM_EN
      CSUM:    byte_d = csum_q;
`endif
      default: emit = 1'b0;
    endcase
  end

  // Issue only once the previous strobe has retired, so strobes never abut.
  assign fire = emit && !full && !almost_full && !wr_en_q;

`ifdef PACKER_CHECKSUM_EN
  assign last_byte = (state_q == CSUM);
`else
  assign last_byte = (state_q == LSB) && (word_cnt_q == LAST_WORD);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= 16'h0;
      word_cnt_q   <= 7'd0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      din_q        <= 8'h00;
      frame_cnt_q  <= 16'h0;
`ifdef PACKER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      wr_en_q      <= fire;
      frame_done_q <= fire && last_byte;
      if (fire) din_q <= byte_d;
      if (fire && last_byte) frame_cnt_q <= frame_cnt_q + 16'd1;
      case (state_q)
        IDLE: if (sample_valid) begin
          state_q    <= SYNC_A;
          word_cnt_q <= 7'd0;
        end
        SYNC_A: if (fire) state_q <= SYNC_B;
        SYNC_B: if (fire) state_q <= LEN;
        LEN: if (fire) begin
          state_q <= WORD;
`ifdef PACKER_CHECKSUM_EN
          csum_q  <= LEN_BYTE;
`endif
        end
        WORD: if (sample_valid) begin
          word_q     <= sample_data;
          word_cnt_q <= word_cnt_q + 7'd1;
          state_q    <= MSB;
        end
        MSB: if (fire) begin
          state_q <= LSB;
`ifdef PACKER_CHECKSUM_EN
          csum_q  <= csum_q + word_q[15:8];
`endif
        end
        LSB: if (fire) begin
`ifdef PACKER_CHECKSUM_EN
          csum_q  <= csum_q + word_q[7:0];
          state_q <= (word_cnt_q == LAST_WORD) ? CSUM : WORD;
`else
          state_q <= (word_cnt_q == LAST_WORD) ? IDLE : WORD;
`endif
        end
`ifdef PACKER_CHECKSUM_EN
        CSUM: if (fire) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = (state_q == WORD);
  assign wr_en        = wr_en_q;
  assign din          = din_q;
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;
endmodule
